// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Two-requester round-robin front end for one shared combinational ALU.
// A granted request is captured, driven to the ALU from the capture registers,
// and the registered result is held on the response port until it is accepted.
//
// Ports
//   clk, reset_n                    clock, asynchronous active-low reset
//   req0_* / req1_*                 valid/ready request handshake, operands, op
//   alu_a, alu_b, alu_ctrl          to the shared ALU (from capture registers)
//   alu_result, alu_zero            from the shared ALU
//   rsp_valid, rsp_ready            response handshake
//   rsp_id, rsp_result, rsp_zero,
//   rsp_err                         response payload
//   gnt_cnt0, gnt_cnt1              saturating per-requester grant counters
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [3:0]   req0_op,
    input  logic [3:0]   req1_op,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_ctrl,
    input  logic [N-1:0] alu_result,
    input  logic         alu_zero,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_result,
    output logic         rsp_zero,
    output logic         rsp_err,
    output logic [15:0]  gnt_cnt0,
    output logic [15:0]  gnt_cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t       state, state_nx;
    logic         ptr;
    logic         gnt_id;
    logic         hs0, hs1, hs;
    logic [N-1:0] cap_a, cap_b;
    logic [3:0]   cap_op;
    logic         cap_id;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: op_legal = 1'b1;
            default:                                     op_legal = 1'b0;
        endcase
    endfunction

    // Grant selection: a lone requester wins, a tie goes to the pointer.
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_id = ptr;
        if (req0_valid && !req1_valid)
            gnt_id = 1'b0;
        else if (req1_valid && !req0_valid)
            gnt_id = 1'b1;
    end

    assign hs0 = req0_valid && req0_ready;
    assign hs1 = req1_valid && req1_ready;
    assign hs  = hs0 || hs1;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic; the spare encoding falls back to IDLE.
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = hs ? EXEC : IDLE;
            EXEC:    state_nx = RESP;
            RESP:    state_nx = rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        req0_ready = (state == IDLE) && req0_valid && (gnt_id == 1'b0);
        req1_ready = (state == IDLE) && req1_valid && (gnt_id == 1'b1);
        rsp_valid  = (state == RESP);
    end

    // The ALU only ever sees captured operands, never live request ports.
    assign alu_a    = cap_a;
    assign alu_b    = cap_b;
    assign alu_ctrl = cap_op;

    // Datapath: capture on handshake, register the ALU return in EXEC, and
    // leave the payload untouched in RESP so it is stable until accepted.
    // NOTE: every register here, payload included, is cleared by reset so an
    // aborted transaction cannot leak a stale payload after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr        <= 1'b0;
            cap_a      <= '0;
            cap_b      <= '0;
            cap_op     <= 4'b0000;
            cap_id     <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            gnt_cnt0   <= 16'd0;
            gnt_cnt1   <= 16'd0;
        end else begin
            if (hs) begin
                ptr    <= ~hs1 ? 1'b1 : 1'b0;
                cap_a  <= hs1 ? req1_a  : req0_a;
                cap_b  <= hs1 ? req1_b  : req0_b;
                cap_op <= hs1 ? req1_op : req0_op;
                cap_id <= hs1;
            end
            if (hs0 && gnt_cnt0 != 16'hFFFF)
                gnt_cnt0 <= gnt_cnt0 + 16'd1;
            if (hs1 && gnt_cnt1 != 16'hFFFF)
                gnt_cnt1 <= gnt_cnt1 + 16'd1;
            if (state == EXEC) begin
                rsp_id <= cap_id;
                if (op_legal(cap_op)) begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_err    <= 1'b0;
                end else begin
                    rsp_result <= '0;
                    rsp_zero   <= 1'b0;
                    rsp_err    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter. A behavioural ALU answers the DUT's
// ALU port; expected responses are queued at each request handshake and
// compared when the DUT's response is accepted.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]   req0_op = '0, req1_op = '0;
    logic [N-1:0] alu_a, alu_b;
    logic [3:0]   alu_ctrl;
    logic [N-1:0] alu_result;
    logic         alu_zero;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic         rsp_id;
    logic [N-1:0] rsp_result;
    logic         rsp_zero, rsp_err;
    logic [15:0]  gnt_cnt0, gnt_cnt1;

    int errors = 0;
    int checks = 0;
    int exp_cnt0 = 0, exp_cnt1 = 0;

    typedef struct {
        bit           id;
        logic [N-1:0] result;
        bit           zero;
        bit           err;
    } exp_t;

    typedef struct {
        bit           id;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [3:0]   op;
        logic [N-1:0] result;
        bit           zero;
        bit           err;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[9];

    alu_arbiter #(.N(N)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    always #5 clk = ~clk;

    // Shared ALU. Unknown codes return a nonzero result with zero set, so the
    // DUT must actively mask both for an illegal op.
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b0111: alu_result = alu_b;
            default: alu_result = (alu_a ^ alu_b) | 64'd1;
        endcase
        case (alu_ctrl)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111:
                alu_zero = (alu_result == '0);
            default: alu_zero = 1'b1;
        endcase
    end

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: sampled on the falling edge, the accepting edge follows.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", rsp_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check("rsp_id", rsp_id, e.id);
                check("rsp_result", rsp_result, e.result);
                check("rsp_zero", rsp_zero, e.zero);
                check("rsp_err", rsp_err, e.err);
            end
        end
    end

    // Single request: wait for grant, queue the expectation, check latency.
    // Returns one cycle into RESP (#1 after the edge).
    task automatic send(input bit id, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [3:0] op, input logic [N-1:0] er, input bit ez, input bit ee);
        bit got = 1'b0;
        if (id) begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
        end
        check("hs_wait", got, 1'b1);
        if (!got) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        check("other_ready", id ? req0_ready : req1_ready, 1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        sb.push_back('{id: id, result: er, zero: ez, err: ee});
        if (id) exp_cnt1++; else exp_cnt0++;
        check("exec_no_valid", rsp_valid, 1'b0);
        @(posedge clk); #1;
        check("resp_valid", rsp_valid, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0) break;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        bit got;
        bit gid;

        vecs[0] = '{id: 0, a: 64'd2,  b: 64'd1,      op: 4'b0010, result: 64'd3,      zero: 0, err: 0};
        vecs[1] = '{id: 1, a: 64'd2,  b: 64'd2,      op: 4'b0110, result: 64'd0,      zero: 1, err: 0};
        vecs[2] = '{id: 0, a: '1,     b: 64'd1,      op: 4'b0010, result: 64'd0,      zero: 1, err: 0};
        vecs[3] = '{id: 1, a: 64'd3,  b: 64'd5,      op: 4'b0011, result: 64'd0,      zero: 0, err: 1};
        vecs[4] = '{id: 1, a: 64'hC,  b: 64'hA,      op: 4'b0000, result: 64'h8,      zero: 0, err: 0};
        vecs[5] = '{id: 0, a: 64'hC,  b: 64'hA,      op: 4'b0001, result: 64'hE,      zero: 0, err: 0};
        vecs[6] = '{id: 0, a: 64'd1,  b: 64'h1234,   op: 4'b0111, result: 64'h1234,   zero: 0, err: 0};
        vecs[7] = '{id: 1, a: 64'd0,  b: 64'd0,      op: 4'b1111, result: 64'd0,      zero: 0, err: 1};
        vecs[8] = '{id: 1, a: 64'd1,  b: 64'd2,      op: 4'b0110, result: '1,         zero: 0, err: 0};

        // Reset values, applied asynchronously between clock edges.
        #2 reset_n = 1'b0;
        #1;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_result", rsp_result, '0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_alu_a", alu_a, '0);
        check("rst_alu_ctrl", alu_ctrl, 4'b0000);
        check("rst_gnt_cnt0", gnt_cnt0, 16'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Both requesters valid continuously: grants must alternate 0,1,0,1.
        req0_a = 64'd5; req0_b = 64'd3; req0_op = 4'b0010;
        req1_a = 64'd5; req1_b = 64'd3; req1_op = 4'b0110;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int g = 0; g < 4; g++) begin
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                @(negedge clk);
                got = req0_ready | req1_ready;
            end
            check("alt_hs", got, 1'b1);
            if (got) begin
                gid = req1_ready;
                check("alt_order", gid, g[0]);
                check("alt_one_ready", req0_ready & req1_ready, 1'b0);
                sb.push_back('{id: gid, result: gid ? 64'd2 : 64'd8, zero: 0, err: 0});
                if (gid) exp_cnt1++; else exp_cnt0++;
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();
        check("alt_gnt_cnt0", gnt_cnt0, 16'd2);
        check("alt_gnt_cnt1", gnt_cnt1, 16'd2);

        // Table of single operations with rsp_ready held high.
        foreach (vecs[k]) begin
            send(vecs[k].id, vecs[k].a, vecs[k].b, vecs[k].op,
                 vecs[k].result, vecs[k].zero, vecs[k].err);
            drain();
        end
        check("tbl_gnt_cnt0", gnt_cnt0, exp_cnt0[15:0]);
        check("tbl_gnt_cnt1", gnt_cnt1, exp_cnt1[15:0]);

        // Back-pressure: payload must hold and no request may be accepted.
        rsp_ready = 1'b0;
        send(1'b0, 64'hF0, 64'h0F, 4'b0001, 64'hFF, 1'b0, 1'b0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", rsp_valid, 1'b1);
            check("stall_result", rsp_result, 64'hFF);
            check("stall_id", rsp_id, 1'b0);
            check("stall_ready0", req0_ready, 1'b0);
            check("stall_ready1", req1_ready, 1'b0);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();

        // Reset during RESP: the pending response is abandoned. The last
        // grant goes to requester 0, so the pointer is 1 when reset hits.
        rsp_ready = 1'b0;
        send(1'b0, 64'd7, 64'd0, 4'b0001, 64'd7, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        sb.delete();
        exp_cnt0 = 0; exp_cnt1 = 0;
        check("rstr_rsp_valid", rsp_valid, 1'b0);
        check("rstr_rsp_result", rsp_result, '0);
        check("rstr_gnt_cnt0", gnt_cnt0, 16'd0);
        check("rstr_gnt_cnt1", gnt_cnt1, 16'd0);
        check("rstr_alu_b", alu_b, '0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("rstr_no_stale", rsp_valid, 1'b0);
        end
        @(posedge clk); #1;
        req0_a = 64'd4; req0_b = 64'd4; req0_op = 4'b0110;
        req1_a = 64'd9; req1_b = 64'd1; req1_op = 4'b0010;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        check("rstr_ptr_ready0", req0_ready, 1'b1);
        check("rstr_ptr_ready1", req1_ready, 1'b0);
        if (req0_ready) begin
            sb.push_back('{id: 1'b0, result: 64'd0, zero: 1'b1, err: 1'b0});
            exp_cnt0++;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();
        check("rstr_gnt_cnt0", gnt_cnt0, exp_cnt0[15:0]);
        check("rstr_gnt_cnt1", gnt_cnt1, exp_cnt1[15:0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
